// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants for the multicycle RISC-V teaching CPU control path:
//   - opcode constants (same values as the single-cycle decoder)
//   - ALUOp codes and ALU B-operand select codes
//   - controller state codes plus the state enum built from them
//   - the registered control-word struct and its per-state decode function
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

    // Opcode field values (IR[6:0])
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_SD    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select codes
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // Controller state codes (visible on the debug port)
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_FETCH     = 4'd1;
    localparam logic [3:0] S_DECODE    = 4'd2;
    localparam logic [3:0] S_MEM_ADDR  = 4'd3;
    localparam logic [3:0] S_MEM_READ  = 4'd4;
    localparam logic [3:0] S_MEM_WB    = 4'd5;
    localparam logic [3:0] S_MEM_WRITE = 4'd6;
    localparam logic [3:0] S_EXEC_R    = 4'd7;
    localparam logic [3:0] S_R_WB      = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_HALT      = 4'd10;

    typedef enum logic [3:0] {
        ST_IDLE      = S_IDLE,
        ST_FETCH     = S_FETCH,
        ST_DECODE    = S_DECODE,
        ST_MEM_ADDR  = S_MEM_ADDR,
        ST_MEM_READ  = S_MEM_READ,
        ST_MEM_WB    = S_MEM_WB,
        ST_MEM_WRITE = S_MEM_WRITE,
        ST_EXEC_R    = S_EXEC_R,
        ST_R_WB      = S_R_WB,
        ST_BRANCH    = S_BRANCH,
        ST_HALT      = S_HALT
    } state_e;

    // Registered control word. fetch_strobe is the unqualified FETCH
    // ir_write/pc_write request; the top ANDs it with mem_ready.
    typedef struct packed {
        logic       fetch_strobe;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       busy;
        logic       illegal;
    } ctrl_t;

    // Moore decode: everything not named for a state stays 0.
    function automatic ctrl_t decode_state(input state_e s);
        ctrl_t c;
        c = '0;
        c.busy = (s != ST_IDLE) && (s != ST_HALT);
        case (s)
            ST_FETCH: begin
                c.fetch_strobe = 1'b1;
                c.mem_read     = 1'b1;
                c.alu_src_b    = SRCB_FOUR;
                c.alu_op       = ALUOP_ADD;
            end
            ST_DECODE: begin
                // ALUOut = PC + imm, the branch target
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                c.pc_write_cond = 1'b1;
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REG;
                c.alu_op        = ALUOP_SUB;
                c.pc_source     = 1'b1;
            end
            ST_HALT: begin
                c.illegal = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/perf_counters.sv
// -----------------------------------------------------------------------------
// perf_counters
// Cycle and retired-instruction counters for the multicycle controller.
// Only instantiated when MULTICYCLE_CONTROL_PERF_CNT_EN is defined.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   busy         controller is in a working state this cycle
//   instr_done   an instruction retires at the end of this cycle
//   cycle_cnt    count of busy cycles (wraps)
//   instr_cnt    count of retired instructions (wraps)
// -----------------------------------------------------------------------------
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             busy,
    input  logic             instr_done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (busy) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        if (instr_done) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Moore main controller for the multicycle RISC-V teaching CPU. Sequences the
// shared ALU, unified memory, IR and register file for R-format, ld, sd and
// beq. Unknown opcodes park the controller in HALT until reset.
//
// Optional feature: define MULTICYCLE_CONTROL_PERF_CNT_EN to add the
// cycle_cnt / instr_cnt performance counter outputs.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   run                leave IDLE / continue at instruction boundaries
//   opcode             IR[6:0], valid from DECODE onward
//   mem_ready          memory completes the current access this cycle
//   pc_write .. pc_source, alu_src_b, alu_op   datapath strobes/selects
//   busy               high in every state except IDLE and HALT
//   illegal            high in HALT
//   state              current state code (debug)
//   cycle_cnt, instr_cnt  performance counters (feature macro only)
// -----------------------------------------------------------------------------
module multicycle_control
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int STATE_W  = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic                pc_source,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                busy,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    localparam logic [OPCODE_W-1:0] OPC_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] OPC_LD    = OPCODE_W'(OP_LD);
    localparam logic [OPCODE_W-1:0] OPC_SD    = OPCODE_W'(OP_SD);
    localparam logic [OPCODE_W-1:0] OPC_BEQ   = OPCODE_W'(OP_BEQ);

    // Counter width must be positive; the empty block only elaborates on a
    // bad configuration and keeps CNT_W referenced in every build.
    if (CNT_W < 1) begin : g_bad_cnt_w
    end

    state_e state_q, state_d;
    ctrl_t  ctrl_q;

    // Instruction boundary: continue fetching only while run is held.
    function automatic state_e boundary_next(input logic r);
        return r ? ST_FETCH : ST_IDLE;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      state_d = boundary_next(run);
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (opcode == OPC_RTYPE) begin
                    state_d = ST_EXEC_R;
                end else if ((opcode == OPC_LD) || (opcode == OPC_SD)) begin
                    state_d = ST_MEM_ADDR;
                end else if (opcode == OPC_BEQ) begin
                    state_d = ST_BRANCH;
                end else begin
                    state_d = ST_HALT;
                end
            end
            // Only ld/sd reach here and the IR is stable, so one compare suffices.
            ST_MEM_ADDR:  state_d = (opcode == OPC_LD) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WB:    state_d = boundary_next(run);
            ST_MEM_WRITE: if (mem_ready) state_d = boundary_next(run);
            ST_EXEC_R:    state_d = ST_R_WB;
            ST_R_WB:      state_d = boundary_next(run);
            ST_BRANCH:    state_d = boundary_next(run);
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;   // unused codes 11-15 recover
        endcase
    end

    // Outputs are registered by decoding the next state, so the control word
    // always matches state_q and is all-zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_state(state_d);
        end
    end

    // FETCH strobes fire only in the cycle the memory access completes, so
    // the IR is loaded and PC+4 written exactly once.
    assign ir_write      = ctrl_q.fetch_strobe & mem_ready;
    assign pc_write      = ctrl_q.fetch_strobe & mem_ready;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign pc_source     = ctrl_q.pc_source;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign busy          = ctrl_q.busy;
    assign illegal       = ctrl_q.illegal;
    assign state         = STATE_W'(state_q);

`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
    logic instr_done;

    // An instruction retires on the edge that leaves its final state.
    assign instr_done = (state_q == ST_MEM_WB) || (state_q == ST_R_WB) ||
                        (state_q == ST_BRANCH) ||
                        ((state_q == ST_MEM_WRITE) && mem_ready);

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf_counters (
        .clk        (clk),
        .rst        (rst),
        .busy       (ctrl_q.busy),
        .instr_done (instr_done),
        .cycle_cnt  (cycle_cnt),
        .instr_cnt  (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench for multicycle_control with a behavioural reference model
// of the instruction flow and a per-cycle compare process.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int IDLE = 0, FETCH = 1, DECODE = 2, MEM_ADDR = 3, MEM_READ = 4,
                   MEM_WB = 5, MEM_WRITE = 6, EXEC_R = 7, R_WB = 8, BRANCH = 9,
                   HALT = 10;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_SD  = 7'b0100011;
    localparam logic [6:0] OPC_BEQ = 7'b1100011;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;

    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, alu_src_a, pc_source, busy, illegal;
    logic [1:0] alu_src_b, alu_op;
    logic [3:0] state;
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    multicycle_control #(
        .OPCODE_W (7),
        .STATE_W  (4),
        .CNT_W    (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .pc_source     (pc_source),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .busy          (busy),
        .illegal       (illegal),
        .state         (state)
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, alu_src_a, pc_source, alu_src_b, alu_op,
                      busy, illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_state = IDLE;
    int unsigned m_cycle = 0;
    int unsigned m_instr = 0;

    function automatic int model_next(input int s, input logic r, input logic [6:0] op,
                                      input logic rdy);
        case (s)
            IDLE:      return r ? FETCH : IDLE;
            FETCH:     return rdy ? DECODE : FETCH;
            DECODE: begin
                if (op == OPC_R) return EXEC_R;
                if (op == OPC_LD || op == OPC_SD) return MEM_ADDR;
                if (op == OPC_BEQ) return BRANCH;
                return HALT;
            end
            MEM_ADDR:  return (op == OPC_LD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  return rdy ? MEM_WB : MEM_READ;
            MEM_WRITE: return rdy ? (r ? FETCH : IDLE) : MEM_WRITE;
            EXEC_R:    return R_WB;
            MEM_WB, R_WB, BRANCH: return r ? FETCH : IDLE;
            HALT:      return HALT;
            default:   return IDLE;
        endcase
    endfunction

    function automatic logic [15:0] model_out(input int s, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, asa, ps, bsy, ill;
        logic [1:0] asb, aop;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, asa, ps, bsy, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        bsy = (s != IDLE) && (s != HALT);
        case (s)
            FETCH:     begin mr = 1; asb = 2'b01; pw = rdy; irw = rdy; end
            DECODE:    begin asb = 2'b10; end
            MEM_ADDR:  begin asa = 1; asb = 2'b10; end
            MEM_READ:  begin mr = 1; iod = 1; end
            MEM_WB:    begin rw = 1; m2r = 1; end
            MEM_WRITE: begin mw = 1; iod = 1; end
            EXEC_R:    begin asa = 1; aop = 2'b10; end
            R_WB:      begin rw = 1; end
            BRANCH:    begin pwc = 1; asa = 1; aop = 2'b01; ps = 1; end
            HALT:      begin ill = 1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, asa, ps, asb, aop, bsy, ill};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = IDLE;
            m_cycle = 0;
            m_instr = 0;
        end else begin
            if (m_state != IDLE && m_state != HALT) m_cycle++;
            if (m_state == MEM_WB || m_state == R_WB || m_state == BRANCH ||
                (m_state == MEM_WRITE && mem_ready)) m_instr++;
            m_state = model_next(m_state, run, opcode, mem_ready);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("state", 32'(state), 32'(m_state));
        chk("outputs", 32'(dut_vec), 32'(model_out(m_state, mem_ready)));
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, m_cycle);
        chk("instr_cnt", instr_cnt, m_instr);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH, holding mem_ready low for the
    // first `waits` cycles of the data-memory state. Checks the state trace
    // (one nibble per cycle) and the cycle count back to FETCH.
    task automatic run_instr(input string nm, input logic [6:0] op, input int waits,
                             input logic [31:0] exp_trace, input int exp_lat);
        int n = 0;
        int w = 0;
        logic [31:0] tr = '0;
        opcode = op;
        do begin
            if ((state == 4'(MEM_READ) || state == 4'(MEM_WRITE)) && w < waits) begin
                mem_ready = 1'b0;
                w++;
            end else begin
                mem_ready = 1'b1;
            end
            step();
            n++;
            tr = (tr << 4) | 32'(state);
            if (state == 4'(EXEC_R)) chk({nm, "_exec_alu_op"}, 32'(alu_op), 32'h2);
            if (state == 4'(R_WB))   chk({nm, "_rwb_reg_write"}, 32'(reg_write), 32'h1);
            if (state == 4'(BRANCH))
                chk({nm, "_branch_strobes"}, 32'({pc_write_cond, alu_op, pc_source}), 32'hB);
        end while (state != 4'(FETCH) && n < 16);
        chk({nm, "_trace"}, tr, exp_trace);
        chk({nm, "_cycles"}, 32'(n), 32'(exp_lat));
    endtask

    initial begin
        step();
        step();
        chk("reset_state", 32'(state), 32'h0);
        chk("reset_outputs", 32'(dut_vec), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_hold", 32'(state), 32'h0);
        end
        run = 1'b1;
        step();
        chk("start_fetch", 32'(state), 32'h1);

        run_instr("rtype", OPC_R,   0, 32'h2781,    4);
        run_instr("ld",    OPC_LD,  2, 32'h2344451, 7);
        run_instr("sd",    OPC_SD,  1, 32'h23661,   5);
        run_instr("beq",   OPC_BEQ, 0, 32'h291,     3);

        // Illegal opcode parks in HALT; run is ignored there.
        opcode    = OPC_BAD;
        mem_ready = 1'b1;
        step();
        step();
        chk("halt_state", 32'(state), 32'hA);
        chk("halt_flags", 32'({illegal, busy}), 32'h2);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            step();
        end
        chk("halt_sticky", 32'(state), 32'hA);
        rst = 1'b1;
        #2;
        chk("halt_rst_state", 32'(state), 32'h0);
        chk("halt_rst_illegal", 32'(illegal), 32'h0);
        step();
        rst = 1'b0;

        // Three R-format instructions, run dropped during the third.
        run       = 1'b1;
        opcode    = OPC_R;
        mem_ready = 1'b1;
        step();
        run_instr("r1", OPC_R, 0, 32'h2781, 4);
        run_instr("r2", OPC_R, 0, 32'h2781, 4);
        step();
        step();
        run = 1'b0;
        step();
        step();
        chk("run_drop_idle", 32'(state), 32'h0);
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
        chk("perf_cycle_lit", cycle_cnt, 32'd12);
        chk("perf_instr_lit", instr_cnt, 32'd3);
`endif

        // Reset in the middle of a stalled FETCH.
        run = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        chk("fetch_stall", 32'(state), 32'h1);
        rst = 1'b1;
        #2;
        chk("midfetch_rst_state", 32'(state), 32'h0);
        chk("midfetch_rst_outputs", 32'(dut_vec), 32'h0);
`ifdef MULTICYCLE_CONTROL_PERF_CNT_EN
        chk("midfetch_rst_cycle", cycle_cnt, 32'd0);
        chk("midfetch_rst_instr", instr_cnt, 32'd0);
`endif
        step();
        rst = 1'b0;
        run = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
